// File: rtl/debug_instr_loader.sv
// debug_instr_loader: assembles a big-endian byte stream from the debug UART
// into 32-bit words and writes each word into the instruction memory through
// its debug port (address / data / one-cycle write strobe).
//
// Ports:
//   i_clk, i_reset        clock (rising edge) and async active-high reset
//   i_Start               one-cycle pulse, starts a load from IDLE or DONE
//   i_RxDone, i_RxData    received-byte strobe and byte
//   o_DirecDebug          memory write address (0, 4, 8, ...)
//   o_DatoDebug           memory write data
//   o_WriteDebug          memory write strobe (one cycle per word)
//   o_Busy, o_Done        load in progress / load finished
//   o_Overflow            sticky: memory filled without a halt word
//   o_Overrun             sticky: byte arrived while a word was being written
module debug_instr_loader #(
  parameter int unsigned      NBITS     = 32,
  parameter int unsigned      CELDAS    = 256,
  parameter logic [NBITS-1:0] HALT_WORD = {NBITS{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Start,
  input  logic             i_RxDone,
  input  logic [7:0]       i_RxData,
  output logic [NBITS-1:0] o_DirecDebug,
  output logic [NBITS-1:0] o_DatoDebug,
  output logic             o_WriteDebug,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Overflow,
  output logic             o_Overrun
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned SHIFT_W = NBITS - BYTE_W;
  localparam int unsigned CNT_W   = 2;
  localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - 4);
  localparam logic [NBITS-1:0] ADDR_STEP = NBITS'(4);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [NBITS-1:0]   addr_q, addr_d;
  logic [NBITS-1:0]   data_q, data_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               ovr_q, ovr_d;

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      // Bytes are ignored here; a start always wins over a simultaneous byte.
      S_IDLE, S_DONE: begin
        if (i_Start) begin
          state_d = S_RECV;
          addr_d  = '0;
          cnt_d   = '0;
          shift_d = '0;
          ovf_d   = 1'b0;
          ovr_d   = 1'b0;
        end
      end
      // First byte received ends up as the MSB of the word.
      S_RECV: begin
        if (i_RxDone) begin
          if (cnt_q != LAST_CNT) begin
            shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], i_RxData};
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            data_d  = {shift_q, i_RxData};
            cnt_d   = '0;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (i_RxDone) ovr_d = 1'b1;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (i_RxDone) ovr_d = 1'b1;
        state_d = S_HOLD;
      end
      // The halt word takes priority over the memory-full check.
      S_HOLD: begin
        if (i_RxDone) ovr_d = 1'b1;
        if (data_q == HALT_WORD) begin
          state_d = S_DONE;
        end else if (addr_q == LAST_ADDR) begin
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_STEP;
          state_d = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase

    write_d = (state_d == S_STROBE);
    busy_d  = (state_d == S_RECV) || (state_d == S_SETUP) ||
              (state_d == S_STROBE) || (state_d == S_HOLD);
    done_d  = (state_d == S_DONE);
  end

  assign o_DirecDebug = addr_q;
  assign o_DatoDebug  = data_q;
  assign o_WriteDebug = write_q;
  assign o_Busy       = busy_q;
  assign o_Done       = done_q;
  assign o_Overflow   = ovf_q;
  assign o_Overrun    = ovr_q;

endmodule

// File: doc/debug_instr_loader.md
# debug_instr_loader

Debug-side writer for the instruction memory's debug write port. Receives a program as a byte stream from the debug UART receiver, assembles big-endian 32-bit words, and issues one address/data/write-strobe transaction per word into the instruction memory. Load ends on the halt word or when memory is full. It sits between the UART RX and the instruction memory and is controlled by the debug unit's top FSM.

## Interface
- NBITS, 32: instruction word width (fixed at 32; four bytes per word).
- CELDAS, 256: number of instruction-memory cells. Addresses are byte-style, PC-compatible: 0, 4, 8, …; last usable address is CELDAS-4.
- HALT_WORD, 32'hFFFFFFFF: end-of-program instruction; it is written to memory, then the load ends.

- i_clk  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_Start  in  1  one-cycle pulse from the debug FSM; starts a load from IDLE or DONE.
- i_RxDone  in  1  one-cycle pulse; i_RxData valid this cycle.
- i_RxData  in  8  received byte.
- o_DirecDebug  out  NBITS  memory write address (drives i_DirecDebug).
- o_DatoDebug  out  NBITS  memory write data (drives i_DatoDebug).
- o_WriteDebug  out  1  write strobe; memory captures on its rising edge.
- o_Busy  out  1  high in RECV/SETUP/STROBE/HOLD.
- o_Done  out  1  high in DONE.
- o_Overflow  out  1  sticky; memory filled without HALT_WORD.
- o_Overrun  out  1  sticky; byte arrived while a word was being written.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also sets the address to 0, the byte counter to 0, the shift register to 0, and the state to IDLE. Reset mid-load discards any partial word. A strobe high at reset falls immediately.
- States: IDLE, RECV, SETUP, STROBE, HOLD, DONE.
- IDLE: i_RxDone is ignored. i_Start -> RECV. Entering RECV clears the address, counter, o_Overflow and o_Overrun.
- RECV: on i_RxDone with count<3, shift reg <= {shift[23:0], i_RxData} and count++.
- RECV: on i_RxDone with count==3, o_DatoDebug <= {shift[23:0], i_RxData}, count <= 0, and the state goes to SETUP. The first byte received is the MSB.
- SETUP: o_DirecDebug and o_DatoDebug are stable and o_WriteDebug=0. The state goes to STROBE.
- STROBE: o_WriteDebug=1 for exactly one cycle. Address and data do not change. The state goes to HOLD.
- HOLD: o_WriteDebug=0. Address and data are held. Exit rules:
  - If o_DatoDebug==HALT_WORD, go to DONE.
  - Otherwise, if o_DirecDebug==CELDAS-4, set o_Overflow and go to DONE.
  - Otherwise, o_DirecDebug += 4 and go to RECV.
- i_RxDone in SETUP/STROBE/HOLD: the byte is dropped and o_Overrun is set. Counter and shift register are unchanged.
- DONE: o_Done=1 and o_Busy=0. Bytes are ignored and do not set o_Overrun. i_Start -> RECV, which behaves as a fresh load.
- i_Start in RECV/SETUP/STROBE/HOLD is ignored.
- If i_Start and i_RxDone are both high in IDLE/DONE, only the start takes effect and the byte is ignored.
- Address arithmetic is NBITS wide. The address never exceeds CELDAS-4, so there is no wrap.

## Timing
- i_Start in cycle 0 -> o_Busy=1 in cycle 1, and bytes are accepted from cycle 1.
- Fourth byte's i_RxDone in cycle t:
  - o_DatoDebug valid from t+1 (SETUP).
  - o_WriteDebug high in t+2 only.
  - HOLD in t+3.
  - From t+4: either RECV with the address +4 visible, or DONE with o_Done=1.
- Address and data are stable for at least 1 cycle before and 1 cycle after the strobe's rising edge.
- Minimum byte spacing without overrun: 4 cycles after the fourth byte of a word. Bytes 1–3 may arrive on consecutive cycles.

## Test plan
- Basic word: Start, then bytes 00,23,00,20 -> one strobe with addr 0 and data 32'h00230020. Then bytes FF×4 -> strobe at addr 4 with 32'hFFFFFFFF, then o_Done=1, o_Busy=0, o_Overflow=0.
- Byte order and address step: load 3 words then the halt word -> strobes at addresses 0,4,8,12 with MSB-first data. Check exactly one o_WriteDebug high cycle per word, and that addr/data are unchanged from SETUP through HOLD.
- Overflow with CELDAS=16: 4 non-halt words -> writes at 0,4,8,12, then DONE with o_Overflow=1. A fifth word produces no strobe.
- Overrun: inject i_RxDone 1 and 2 cycles after a word's fourth byte -> o_Overrun=1 and both bytes are dropped. The next 4 bytes form the next word correctly.
- Reset mid-load: assert i_reset after 2 bytes of word 1 (and separately during STROBE) -> all outputs 0 at once, state IDLE. A new Start and full word writes to addr 0.
- Restart from DONE: after an overflow load, pulse i_Start -> o_Overflow/o_Overrun cleared and address 0. Bytes received in DONE before the Start cause no writes.
